// File: rtl/read_req_initiator.sv
// Read-request initiator: issues a programmed burst of read addresses, tracks
// outstanding requests, and forwards in-order returned data through a one-entry register.
module read_req_initiator #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
  input  logic [ADDR_WIDTH-1:0]                  stride,
  input  logic [CNT_WIDTH-1:0]                   num_reqs,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err_unexpected,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   req_addr_tvalid,
  input  logic                                   req_addr_tready,
  output logic [ADDR_WIDTH-1:0]                  req_addr_tdata,
  input  logic                                   bak_data_tvalid,
  output logic                                   bak_data_tready,
  input  logic [DATA_WIDTH-1:0]                  bak_data_tdata,
  output logic                                   out_tvalid,
  input  logic                                   out_tready,
  output logic [DATA_WIDTH-1:0]                  out_tdata
);

  // Handshake rule for all three streams: a beat transfers on the rising clk edge
  // where tvalid and tready are both high; a raised tvalid and its tdata stay put
  // until that edge.

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic [CNT_WIDTH-1:0]  received;
  logic [OW-1:0]         outstanding_q;
  logic                  err_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  running;

  logic start_acc;
  logic slot_free;
  logic req_hs;
  logic bak_hs;
  logic resp_stray;
  logic resp_expected;
  logic last_issue;

  assign start_acc     = start && (state == IDLE);
  assign slot_free     = outstanding_q < MAX_CNT;
  assign req_hs        = req_addr_tvalid && req_addr_tready;
  assign bak_hs        = bak_data_tvalid && bak_data_tready;
  assign resp_stray    = bak_hs && (outstanding_q == '0);
  assign resp_expected = bak_hs && !resp_stray;
  assign last_issue    = (issued + 1'b1) == num_q;

  // running keeps bak_data_tready low while reset is held.
  assign req_addr_tvalid = (state == ISSUE) && slot_free;
  assign req_addr_tdata  = addr_q;
  assign bak_data_tready = running && (!out_valid_q || out_tready);
  assign out_tvalid      = out_valid_q;
  assign out_tdata       = out_data_q;
  assign busy            = (state == ISSUE) || (state == DRAIN);
  assign done            = (state == DONE);
  assign err_unexpected  = err_q;
  assign outstanding     = outstanding_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_reqs == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (req_hs && last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the last beat to leave the output register too.
        if ((received == num_q) && !out_valid_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      stride_q <= '0;
      num_q    <= '0;
      issued   <= '0;
    end else if (start_acc) begin
      addr_q   <= base_addr;
      stride_q <= stride;
      num_q    <= num_reqs;
      issued   <= '0;
    end else if (req_hs) begin
      addr_q   <= addr_q + stride_q;
      issued   <= issued + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      case ({req_hs, resp_expected})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // A stray response in the same cycle as an accepted start still flags the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      received <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        received <= '0;
        err_q    <= 1'b0;
      end else if (resp_expected) begin
        received <= received + 1'b1;
      end
      if (resp_stray) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bak_hs) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bak_data_tdata;
    end else if (out_tready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_req_initiator.sv
// Directed bench for read_req_initiator: echoing responder, request/response
// scoreboard, outstanding model and stall-stability checks.
module tb_read_req_initiator;
  localparam int AW   = 48;
  localparam int DW   = 64;
  localparam int MAXO = 2;
  localparam int CW   = 16;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] num_reqs = '0;
  logic          busy;
  logic          done;
  logic          err_unexpected;
  logic [OW-1:0] outstanding;
  logic          req_addr_tvalid;
  logic          req_addr_tready = 1'b1;
  logic [AW-1:0] req_addr_tdata;
  logic          bak_data_tvalid = 1'b0;
  logic          bak_data_tready;
  logic [DW-1:0] bak_data_tdata = '0;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic [DW-1:0] out_tdata;

  read_req_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .num_reqs(num_reqs), .busy(busy), .done(done), .err_unexpected(err_unexpected),
    .outstanding(outstanding), .req_addr_tvalid(req_addr_tvalid),
    .req_addr_tready(req_addr_tready), .req_addr_tdata(req_addr_tdata),
    .bak_data_tvalid(bak_data_tvalid), .bak_data_tready(bak_data_tready),
    .bak_data_tdata(bak_data_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tdata(out_tdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] resp_q[$];
  int            resp_t[$];
  logic [AW-1:0] req_log[$];
  int cyc = 0;
  int req_cnt = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int model_out = 0;
  int max_out = 0;
  int lat = 3;
  bit rdy_rand = 1'b0;
  bit out_stall = 1'b0;
  bit inj_valid = 1'b0;
  logic [DW-1:0] inj_data = '0;
  bit bak_from_q = 1'b0;
  bit prev_req_stall = 1'b0;
  bit prev_out_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // responder and ready drivers, updated 2 units after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    bak_from_q = 1'b0;
    if (rst) begin
      bak_data_tvalid = 1'b0;
    end else if (inj_valid) begin
      bak_data_tvalid = 1'b1;
      bak_data_tdata  = inj_data;
    end else if (resp_q.size() > 0 && cyc >= resp_t[0]) begin
      bak_data_tvalid = 1'b1;
      bak_data_tdata  = DW'(resp_q[0]);
      bak_from_q      = 1'b1;
    end else begin
      bak_data_tvalid = 1'b0;
    end
    req_addr_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    out_tready      = !out_stall;
  end

  // monitor / scoreboard on the falling edge
  initial forever begin
    bit rhs;
    bit bhs;
    bit ohs;
    @(negedge clk);
    if (rst) begin
      prev_req_stall = 1'b0;
      prev_out_stall = 1'b0;
      model_out = 0;
    end else begin
      rhs = req_addr_tvalid && req_addr_tready;
      bhs = bak_data_tvalid && bak_data_tready;
      ohs = out_tvalid && out_tready;
      check("outstanding", 64'(outstanding), 64'(model_out));
      if (model_out == MAXO) check("req_valid_at_max", 64'(req_addr_tvalid), 64'd0);
      if (prev_req_stall) begin
        check("req_valid_hold", 64'(req_addr_tvalid), 64'd1);
        check("req_addr_hold", 64'(req_addr_tdata), 64'(prev_addr));
      end
      if (prev_out_stall) begin
        check("out_valid_hold", 64'(out_tvalid), 64'd1);
        check("out_data_hold", out_tdata, prev_data);
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", 64'(busy), 64'd0);
      end
      if (rhs) begin
        req_cnt++;
        req_log.push_back(req_addr_tdata);
        if (exp_addr_q.size() == 0) begin
          check("req_extra", 64'd1, 64'd0);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_addr_q.pop_front();
          check("req_addr", 64'(req_addr_tdata), 64'(ea));
          exp_q.push_back(DW'(ea));
        end
        resp_q.push_back(req_addr_tdata);
        resp_t.push_back(cyc + lat);
      end
      if (bhs && bak_from_q) begin
        void'(resp_q.pop_front());
        void'(resp_t.pop_front());
      end
      if (ohs) begin
        out_cnt++;
        if (exp_q.size() == 0) check("out_extra", 64'd1, 64'd0);
        else check("out_data", out_tdata, exp_q.pop_front());
      end
      model_out = model_out + int'(rhs) - int'(bhs && model_out > 0);
      if (model_out > max_out) max_out = model_out;
      prev_req_stall = req_addr_tvalid && !req_addr_tready;
      prev_addr      = req_addr_tdata;
      prev_out_stall = out_tvalid && !out_tready;
      prev_data      = out_tdata;
    end
  end

  // driver tasks
  task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int n, input int l);
    logic [AW-1:0] a;
    a = b;
    lat = l;
    req_log.delete();
    req_cnt = 0;
    out_cnt = 0;
    max_out = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(a);
      a = a + s;
    end
    @(posedge clk);
    #1;
    base_addr = b;
    stride    = s;
    num_reqs  = CW'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = '1;
    stride    = '1;
    num_reqs  = '1;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_outstanding_zero"}, 64'(outstanding), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err_unexpected), 64'd0);
    check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    check({tag, "_req_valid"}, 64'(req_addr_tvalid), 64'd0);
    check({tag, "_req_data"}, 64'(req_addr_tdata), 64'd0);
    check({tag, "_bak_ready"}, 64'(bak_data_tready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_tvalid), 64'd0);
    check({tag, "_out_data"}, out_tdata, 64'd0);
  endtask

  initial begin
    int d0;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic burst
    d0 = done_cnt;
    start_burst(48'h1000, 48'd8, 4, 3);
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_first_valid", 64'(req_addr_tvalid), 64'd1);
    check("basic_first_addr", 64'(req_addr_tdata), 64'h1000);
    wait_done(d0, 200, "basic");
    check("basic_addr0", 64'(req_log[0]), 64'h1000);
    check("basic_addr1", 64'(req_log[1]), 64'h1008);
    check("basic_addr2", 64'(req_log[2]), 64'h1010);
    check("basic_addr3", 64'(req_log[3]), 64'h1018);
    check("basic_out_cnt", 64'(out_cnt), 64'd4);

    // outstanding limit with slow responder
    d0 = done_cnt;
    start_burst(48'h2000, 48'd4, 6, 16);
    wait_done(d0, 500, "limit");
    check("limit_max_out", 64'(max_out), 64'd2);
    check("limit_out_cnt", 64'(out_cnt), 64'd6);

    // output stall plus random request ready
    d0 = done_cnt;
    rdy_rand = 1'b1;
    start_burst(48'h3000, 48'd32, 8, 3);
    repeat (6) @(posedge clk);
    #1;
    out_stall = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    out_stall = 1'b0;
    wait_done(d0, 500, "bp");
    rdy_rand = 1'b0;
    check("bp_req_cnt", 64'(req_cnt), 64'd8);
    check("bp_out_cnt", 64'(out_cnt), 64'd8);

    // zero-length burst
    d0 = done_cnt;
    start_burst(48'h55, 48'd1, 0, 3);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_req_valid", 64'(req_addr_tvalid), 64'd0);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_done_count", 64'(done_cnt - d0), 64'd1);
    check("zero_req_cnt", 64'(req_cnt), 64'd0);

    // address wrap
    d0 = done_cnt;
    start_burst(48'hFFFF_FFFF_FFF8, 48'd16, 2, 3);
    wait_done(d0, 200, "wrap");
    check("wrap_addr0", 64'(req_log[0]), 64'hFFFF_FFFF_FFF8);
    check("wrap_addr1", 64'(req_log[1]), 64'h8);

    // stray response while idle
    out_cnt = 0;
    exp_q.push_back(64'hDEAD);
    @(posedge clk);
    #1;
    inj_data  = 64'hDEAD;
    inj_valid = 1'b1;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_err", 64'(err_unexpected), 64'd1);
    check("stray_forwarded", 64'(out_cnt), 64'd1);
    check("stray_outstanding", 64'(outstanding), 64'd0);
    d0 = done_cnt;
    start_burst(48'h4000, 48'd8, 2, 3);
    check("stray_err_cleared", 64'(err_unexpected), 64'd0);
    wait_done(d0, 200, "after_stray");

    // reset in the middle of a burst
    d0 = done_cnt;
    start_burst(48'h5000, 48'd8, 8, 3);
    k = 0;
    while (req_cnt < 3 && k < 200) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("midrst_reached_3", 64'(req_cnt >= 3), 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    resp_q.delete();
    resp_t.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_burst(48'h6000, 48'd8, 8, 2);
    wait_done(d0, 500, "fresh");
    check("fresh_out_cnt", 64'(out_cnt), 64'd8);
    check("fresh_last_addr", 64'(req_log[7]), 64'h6038);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
